// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding and a
// constant-width helper.
package booth_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Round-robin picker: the first set request at or after ptr, wrapping.
// Rotate so ptr sits at bit 0, priority-encode, then rotate the index back.
module rr_pick
  import booth_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     sum;
  logic [ID_W:0]     sub;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) off = ID_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    sub = sum - (ID_W+1)'(NREQ);
    idx = (sum >= (ID_W+1)'(NREQ)) ? sub[ID_W-1:0] : sum[ID_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential Booth multiplier among NREQ requesters: round-robin
// grant, start pulse, wait for done (or timeout), tagged valid/ready response.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int WIDTH   = 4,
  parameter  int TIMEOUT = 31,
  localparam int ID_W    = clog2(NREQ),
  localparam int TW      = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  mult_valid,
  output logic [WIDTH-1:0]      mult_a,
  output logic [WIDTH-1:0]      mult_b,
  input  logic                  mult_done,
  input  logic [2*WIDTH-1:0]    mult_prod,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prod,
  output logic                  rsp_err,
  output logic                  busy
);

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id_q;
  logic [TW-1:0]   timer;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      id_q       <= '0;
      timer      <= '0;
      gnt        <= '0;
      mult_valid <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_prod   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // gnt and mult_valid are single-cycle pulses covering the ISSUE state
      gnt        <= '0;
      mult_valid <= 1'b0;
      case (state)
        S_IDLE: if (pick_any) begin
          id_q       <= pick_idx;
          mult_a     <= a_in[pick_idx*WIDTH +: WIDTH];
          mult_b     <= b_in[pick_idx*WIDTH +: WIDTH];
          gnt        <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          mult_valid <= 1'b1;
          busy       <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done beats timeout when both land on the same cycle
          if (mult_done) begin
            rsp_prod  <= mult_prod;
            rsp_err   <= 1'b0;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_prod  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter: stimulus pushes expected grants and
// responses, monitors pop and compare; a behavioural multiplier answers starts.
module tb_booth_mult_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
    logic       err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        mult_valid;
  logic [3:0]  mult_a, mult_b;
  logic        mult_done;
  logic [7:0]  mult_prod;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        rsp_err;
  logic        busy;

  logic        mdl_done, inj_done;
  logic [7:0]  mdl_prod, inj_prod;
  int          mult_lat;
  int          pass_cnt, tot_cnt, gnt_cnt;
  rsp_t        exp_rsp[$];
  logic [3:0]  exp_gnt[$];

  assign mult_done = mdl_done | inj_done;
  assign mult_prod = inj_done ? inj_prod : mdl_prod;

  booth_mult_arbiter #(.NREQ(4), .WIDTH(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .mult_valid(mult_valid), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_prod(mult_prod), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural multiplier: answers a start after mult_lat cycles, 0 = never.
  always begin : mult_model
    logic [3:0] pa, pb;
    logic       abort;
    @(negedge clk);
    if (rst && mult_valid && mult_lat != 0) begin
      pa = mult_a;
      pb = mult_b;
      abort = 1'b0;
      for (int i = 0; i < mult_lat; i++) begin
        @(posedge clk);
        if (!rst) abort = 1'b1;
      end
      #1;
      if (!abort && rst) begin
        mdl_prod = 8'($signed({{4{pa[3]}}, pa}) * $signed({{4{pb[3]}}, pb}));
        mdl_done = 1'b1;
        @(posedge clk);
        #1 mdl_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : gnt_mon
    logic [3:0] e;
    if (rst && gnt != 4'b0) begin
      chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (exp_gnt.size() == 0) begin
        tot_cnt++;
        $display("FAIL gnt_unexpected: got %b expected none", gnt);
      end else begin
        e = exp_gnt.pop_front();
        chk("gnt_order", 32'(gnt), 32'(e));
      end
      gnt_cnt++;
    end
  end

  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        tot_cnt++;
        $display("FAIL rsp_unexpected: got id=%0d prod=%h err=%b expected none",
                 rsp_id, rsp_prod, rsp_err);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp", 32'({rsp_id, rsp_prod, rsp_err}), 32'(e));
      end
    end
  end

  task automatic wait_gnt(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[id] && n < 100);
    chk("gnt_seen", 32'(gnt[id]), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk("idle", 32'(busy), 32'd0);
  endtask

  // One full operation with rsp_ready high; lat=0 exercises the timeout path.
  task automatic do_op(input logic [3:0] rv, input int id, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] prod, input int lat);
    int n;
    @(posedge clk);
    #1;
    a_in[id*4 +: 4] = a;
    b_in[id*4 +: 4] = b;
    mult_lat = lat;
    exp_gnt.push_back(4'b0001 << id);
    exp_rsp.push_back('{2'(id), prod, (lat == 0)});
    req = rv;
    wait_gnt(id);
    chk("start_pulse", 32'(mult_valid), 32'd1);
    chk("mult_a", 32'(mult_a), 32'(a));
    chk("mult_b", 32'(mult_b), 32'(b));
    @(posedge clk);
    #1 req = 4'b0;
    @(negedge clk);
    chk("gnt_one_cycle", 32'({gnt, mult_valid}), 32'd0);
    if (lat > 0) begin
      n = 0;
      while (!mult_done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", 32'(mult_done), 32'd1);
      @(negedge clk);
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
    end else begin
      n = rsp_valid ? 0 : 1;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        if (!rsp_valid) n++;
      end
      chk("timeout_cycles", 32'(n), 32'd31);
    end
    @(negedge clk);
    chk("idle_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, n;
    rst = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
    mdl_done = 1'b0; mdl_prod = '0; inj_done = 1'b0; inj_prod = '0;
    mult_lat = 0; pass_cnt = 0; tot_cnt = 0; gnt_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({gnt, mult_valid, mult_a, mult_b, rsp_valid, rsp_id,
                            rsp_prod, rsp_err, busy}), 32'd0);
    #2 rst = 1'b1;

    // 3 * -2 = -6
    do_op(4'b0001, 0, 4'd3, 4'b1110, 8'hFA, 6);
    do_op(4'b0010, 1, 4'd2, 4'd5, 8'h0A, 2);

    // abort mid-WAIT with ptr at 2; afterwards ptr must be back at 0
    a_in[8 +: 4] = 4'd1; b_in[8 +: 4] = 4'd2; mult_lat = 6;
    exp_gnt.push_back(4'b0100);
    @(posedge clk);
    #1 req = 4'b0100;
    wait_gnt(2);
    @(posedge clk);
    #1 req = 4'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset", 32'({busy, gnt, mult_valid, rsp_valid, rsp_prod, rsp_err}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    do_op(4'b1001, 0, 4'd1, 4'd1, 8'h01, 3);

    do_op(4'b1000, 3, 4'd5, 4'd5, 8'h00, 0);

    // all four requesting from ptr=0
    a_in = {4'h8, 4'h7, 4'hF, 4'h2};
    b_in = {4'h8, 4'h7, 4'h5, 4'h3};
    mult_lat = 5;
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001);
    exp_rsp.push_back('{2'd0, 8'h06, 1'b0}); exp_rsp.push_back('{2'd1, 8'hFB, 1'b0});
    exp_rsp.push_back('{2'd2, 8'h31, 1'b0}); exp_rsp.push_back('{2'd3, 8'h40, 1'b0});
    exp_rsp.push_back('{2'd0, 8'h06, 1'b0});
    base = gnt_cnt;
    @(posedge clk);
    #1 req = 4'hF;
    n = 0;
    while (gnt_cnt < base + 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rr_grants", 32'(gnt_cnt - base), 32'd5);
    @(posedge clk);
    #1 req = 4'b0;
    wait_idle();

    // response back-pressure with 0110 pending, last id = 1
    a_in[4 +: 4] = 4'd5; b_in[4 +: 4] = 4'hD; mult_lat = 3;
    exp_gnt.push_back(4'b0010);
    exp_rsp.push_back('{2'd1, 8'hF1, 1'b0});
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req = 4'b0010;
    wait_gnt(1);
    @(posedge clk);
    #1 req = 4'b0110;
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'({rsp_valid, rsp_id, rsp_prod, rsp_err, gnt}),
          32'({1'b1, 2'd1, 8'hF1, 1'b0, 4'b0000}));
    end
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b0010);
    exp_rsp.push_back('{2'd2, 8'h31, 1'b0}); exp_rsp.push_back('{2'd1, 8'hF1, 1'b0});
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_gnt(2);
    @(posedge clk);
    #1 req = 4'b0010;
    wait_gnt(1);
    @(posedge clk);
    #1 req = 4'b0;
    wait_idle();

    // stale done in IDLE and in ISSUE; -3 * 4 = -12
    a_in[0 +: 4] = 4'hD; b_in[0 +: 4] = 4'd4; mult_lat = 4;
    @(posedge clk);
    #1 begin inj_done = 1'b1; inj_prod = 8'h55; end
    @(posedge clk);
    #1 inj_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", 32'({busy, rsp_valid, gnt}), 32'd0);
    exp_gnt.push_back(4'b0001);
    exp_rsp.push_back('{2'd0, 8'hF4, 1'b0});
    @(posedge clk);
    #1 req = 4'b0001;
    @(posedge clk);
    #1 begin inj_done = 1'b1; inj_prod = 8'hAA; end
    @(negedge clk);
    chk("issue_cycle", 32'(gnt), 32'd1);
    @(posedge clk);
    #1 begin inj_done = 1'b0; req = 4'b0; end
    wait_idle();

    @(negedge clk);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
